// File: rtl/spu_mem_stage.sv
// SPU MEM stage: local-store access for both pipes, registered MEM/WB outputs.
// Latency: 1 cycle; a same-bundle dual memory access costs one extra (bubble) cycle.
// Backpressure: stall_MEM is high for exactly one cycle on a dual memory access; upstream holds inputs.
module spu_mem_stage #(
    parameter int LS_ADDR_W = 11,
    parameter int DATA_W    = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memToReg_MEM1,
    input  logic              regWriteEnable_MEM1,
    input  logic              memRead_MEM1,
    input  logic              memWrite_MEM1,
    input  logic              memToReg_MEM2,
    input  logic              regWriteEnable_MEM2,
    input  logic              memRead_MEM2,
    input  logic              memWrite_MEM2,
    input  logic [DATA_W-1:0] result_MEM1,
    input  logic [DATA_W-1:0] result_MEM2,
    input  logic [DATA_W-1:0] readDataRC_MEM1,
    input  logic [DATA_W-1:0] readDataRC_MEM2,
    input  logic [6:0]        registerRT_MEM1,
    input  logic [6:0]        registerRT_MEM2,
    output logic              stall_MEM,
    output logic              memToReg_WB1,
    output logic              regWriteEnable_WB1,
    output logic              memToReg_WB2,
    output logic              regWriteEnable_WB2,
    output logic [DATA_W-1:0] result_WB1,
    output logic [DATA_W-1:0] result_WB2,
    output logic [DATA_W-1:0] loadData_WB1,
    output logic [DATA_W-1:0] loadData_WB2,
    output logic [6:0]        registerRT_WB1,
    output logic [6:0]        registerRT_WB2
);

    typedef enum logic {IDLE, SERVE2} state_t;

    typedef struct packed {
        logic              mem_to_reg;
        logic              reg_we;
        logic [DATA_W-1:0] result;
        logic [6:0]        rt;
        logic [DATA_W-1:0] load;
    } wb_t;

    logic [DATA_W-1:0] ls_mem [0:(1<<LS_ADDR_W)-1];

    state_t state_q, state_d;
    wb_t    hold_q, hold_d;
    wb_t    wb1_q, wb1_d;
    wb_t    wb2_q, wb2_d;

    logic                 mem_op1, mem_op2;
    logic                 load1, load2;
    logic [LS_ADDR_W-1:0] addr1, addr2;
    logic                 use_p2;
    logic [LS_ADDR_W-1:0] acc_addr;
    logic                 acc_we;
    logic [DATA_W-1:0]    acc_wdata;
    logic [DATA_W-1:0]    acc_rdata;
    logic [DATA_W-1:0]    ld1, ld2;

    assign mem_op1 = memRead_MEM1 | memWrite_MEM1;
    assign mem_op2 = memRead_MEM2 | memWrite_MEM2;
    // A write wins over a read flagged on the same pipe.
    assign load1   = memRead_MEM1 & ~memWrite_MEM1;
    assign load2   = memRead_MEM2 & ~memWrite_MEM2;
    assign addr1   = result_MEM1[LS_ADDR_W+3:4];
    assign addr2   = result_MEM2[LS_ADDR_W+3:4];

    assign stall_MEM = ~reset & (state_q == IDLE) & mem_op1 & mem_op2;

    // Single port: pipe 2 owns it in SERVE2, or in IDLE when pipe 1 has no memory op.
    assign use_p2    = (state_q == SERVE2) | ~mem_op1;
    assign acc_addr  = use_p2 ? addr2 : addr1;
    assign acc_wdata = use_p2 ? readDataRC_MEM2 : readDataRC_MEM1;
    assign acc_we    = ~reset & (use_p2 ? memWrite_MEM2 : memWrite_MEM1);
    assign acc_rdata = ls_mem[acc_addr];

    assign ld1 = load1 ? acc_rdata : '0;
    assign ld2 = load2 ? acc_rdata : '0;

    always_ff @(posedge clk) begin
        if (acc_we) begin
            ls_mem[acc_addr] <= acc_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        wb1_d   = '0;
        wb2_d   = '0;
        case (state_q)
            IDLE: begin
                if (mem_op1 && mem_op2) begin
                    // Pipe 1 retires later alongside pipe 2; WB sees a bubble now.
                    state_d           = SERVE2;
                    hold_d.mem_to_reg = memToReg_MEM1;
                    hold_d.reg_we     = regWriteEnable_MEM1;
                    hold_d.result     = result_MEM1;
                    hold_d.rt         = registerRT_MEM1;
                    hold_d.load       = ld1;
                end else begin
                    wb1_d.mem_to_reg = memToReg_MEM1;
                    wb1_d.reg_we     = regWriteEnable_MEM1;
                    wb1_d.result     = result_MEM1;
                    wb1_d.rt         = registerRT_MEM1;
                    wb1_d.load       = ld1;
                    wb2_d.mem_to_reg = memToReg_MEM2;
                    wb2_d.reg_we     = regWriteEnable_MEM2;
                    wb2_d.result     = result_MEM2;
                    wb2_d.rt         = registerRT_MEM2;
                    wb2_d.load       = ld2;
                end
            end
            SERVE2: begin
                state_d          = IDLE;
                wb1_d            = hold_q;
                wb2_d.mem_to_reg = memToReg_MEM2;
                wb2_d.reg_we     = regWriteEnable_MEM2;
                wb2_d.result     = result_MEM2;
                wb2_d.rt         = registerRT_MEM2;
                wb2_d.load       = ld2;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            wb1_q   <= '0;
            wb2_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wb1_q   <= wb1_d;
            wb2_q   <= wb2_d;
        end
    end

    assign memToReg_WB1       = wb1_q.mem_to_reg;
    assign regWriteEnable_WB1 = wb1_q.reg_we;
    assign result_WB1         = wb1_q.result;
    assign registerRT_WB1     = wb1_q.rt;
    assign loadData_WB1       = wb1_q.load;
    assign memToReg_WB2       = wb2_q.mem_to_reg;
    assign regWriteEnable_WB2 = wb2_q.reg_we;
    assign result_WB2         = wb2_q.result;
    assign registerRT_WB2     = wb2_q.rt;
    assign loadData_WB2       = wb2_q.load;

    stall_single_cycle: assert property (@(posedge clk) disable iff (reset) stall_MEM |=> !stall_MEM);

endmodule

// File: tb/tb_spu_mem_stage.sv
// Scoreboard bench for spu_mem_stage: reference local-store model, one expected WB record per cycle.
module tb_spu_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         memToReg_MEM1, regWriteEnable_MEM1, memRead_MEM1, memWrite_MEM1;
    logic         memToReg_MEM2, regWriteEnable_MEM2, memRead_MEM2, memWrite_MEM2;
    logic [127:0] result_MEM1, result_MEM2, readDataRC_MEM1, readDataRC_MEM2;
    logic [6:0]   registerRT_MEM1, registerRT_MEM2;
    logic         stall_MEM;
    logic         memToReg_WB1, regWriteEnable_WB1, memToReg_WB2, regWriteEnable_WB2;
    logic [127:0] result_WB1, result_WB2, loadData_WB1, loadData_WB2;
    logic [6:0]   registerRT_WB1, registerRT_WB2;

    typedef struct {
        logic         m2r, rwe, rd, wr;
        logic [127:0] res, rc;
        logic [6:0]   rt;
    } pipe_t;

    typedef struct {
        logic [264:0] p1;
        logic [264:0] p2;
    } exp_t;

    exp_t         sb [$];
    logic [127:0] model [0:2047];
    int           checks = 0;
    int           errors = 0;

    localparam logic [127:0] PAT_A = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] PAT_B = {16{8'hAA}};

    spu_mem_stage #(.LS_ADDR_W(11), .DATA_W(128)) dut (
        .clk(clk), .reset(reset),
        .memToReg_MEM1(memToReg_MEM1), .regWriteEnable_MEM1(regWriteEnable_MEM1),
        .memRead_MEM1(memRead_MEM1), .memWrite_MEM1(memWrite_MEM1),
        .memToReg_MEM2(memToReg_MEM2), .regWriteEnable_MEM2(regWriteEnable_MEM2),
        .memRead_MEM2(memRead_MEM2), .memWrite_MEM2(memWrite_MEM2),
        .result_MEM1(result_MEM1), .result_MEM2(result_MEM2),
        .readDataRC_MEM1(readDataRC_MEM1), .readDataRC_MEM2(readDataRC_MEM2),
        .registerRT_MEM1(registerRT_MEM1), .registerRT_MEM2(registerRT_MEM2),
        .stall_MEM(stall_MEM),
        .memToReg_WB1(memToReg_WB1), .regWriteEnable_WB1(regWriteEnable_WB1),
        .memToReg_WB2(memToReg_WB2), .regWriteEnable_WB2(regWriteEnable_WB2),
        .result_WB1(result_WB1), .result_WB2(result_WB2),
        .loadData_WB1(loadData_WB1), .loadData_WB2(loadData_WB2),
        .registerRT_WB1(registerRT_WB1), .registerRT_WB2(registerRT_WB2)
    );

    always #5 clk = ~clk;

    function automatic pipe_t mk(input logic m2r, input logic rwe, input logic rd, input logic wr,
                                 input logic [127:0] res, input logic [127:0] rc, input logic [6:0] rt);
        pipe_t p;
        p.m2r = m2r; p.rwe = rwe; p.rd = rd; p.wr = wr;
        p.res = res; p.rc = rc; p.rt = rt;
        return p;
    endfunction

    task automatic drive(input pipe_t p1, input pipe_t p2);
        memToReg_MEM1 = p1.m2r; regWriteEnable_MEM1 = p1.rwe;
        memRead_MEM1 = p1.rd; memWrite_MEM1 = p1.wr;
        result_MEM1 = p1.res; readDataRC_MEM1 = p1.rc; registerRT_MEM1 = p1.rt;
        memToReg_MEM2 = p2.m2r; regWriteEnable_MEM2 = p2.rwe;
        memRead_MEM2 = p2.rd; memWrite_MEM2 = p2.wr;
        result_MEM2 = p2.res; readDataRC_MEM2 = p2.rc; registerRT_MEM2 = p2.rt;
    endtask

    // Pushes expected WB records from the reference model, drives one bundle and checks each WB cycle.
    task automatic run_bundle(input pipe_t p1, input pipe_t p2, input string name);
        exp_t         e, got, x;
        logic [10:0]  a1, a2;
        logic [127:0] l1, l2;
        bit           conf;
        int           ncyc;
        a1 = p1.res[14:4];
        a2 = p2.res[14:4];
        conf = (p1.rd || p1.wr) && (p2.rd || p2.wr);
        l1 = (p1.rd && !p1.wr) ? model[a1] : 128'h0;
        if (p1.wr) model[a1] = p1.rc;
        l2 = (p2.rd && !p2.wr) ? model[a2] : 128'h0;
        if (p2.wr) model[a2] = p2.rc;
        e.p1 = {p1.m2r, p1.rwe, p1.rt, p1.res, l1};
        e.p2 = {p2.m2r, p2.rwe, p2.rt, p2.res, l2};
        if (conf) begin
            x.p1 = '0;
            x.p2 = '0;
            sb.push_back(x);
        end
        sb.push_back(e);
        drive(p1, p2);
        #1;
        checks++;
        if (stall_MEM !== conf) begin
            errors++;
            $display("FAIL %s stall_MEM got %b want %b", name, stall_MEM, conf);
        end
        ncyc = conf ? 2 : 1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            x = sb.pop_front();
            got.p1 = {memToReg_WB1, regWriteEnable_WB1, registerRT_WB1, result_WB1, loadData_WB1};
            got.p2 = {memToReg_WB2, regWriteEnable_WB2, registerRT_WB2, result_WB2, loadData_WB2};
            checks++;
            if (got.p1 !== x.p1) begin
                errors++;
                $display("FAIL %s wb1 cyc%0d got %h want %h", name, c, got.p1, x.p1);
            end
            checks++;
            if (got.p2 !== x.p2) begin
                errors++;
                $display("FAIL %s wb2 cyc%0d got %h want %h", name, c, got.p2, x.p2);
            end
            if (c == 0 && conf) begin
                checks++;
                if (stall_MEM !== 1'b0) begin
                    errors++;
                    $display("FAIL %s stall_second_cycle got %b want 0", name, stall_MEM);
                end
            end
        end
    endtask

    task automatic test_reset();
        pipe_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        // Loads on both pipes under reset: stall must still be suppressed.
        drive(mk(1, 1, 1, 0, 128'h40, 0, 7'd5), mk(1, 1, 1, 0, 128'h80, 0, 7'd6));
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stall_MEM !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got %b want 0", stall_MEM);
        end
        checks++;
        if ({memToReg_WB1, regWriteEnable_WB1, memToReg_WB2, regWriteEnable_WB2, result_WB1, result_WB2,
             loadData_WB1, loadData_WB2, registerRT_WB1, registerRT_WB2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got r1=%h r2=%h l1=%h l2=%h want 0", result_WB1, result_WB2,
                     loadData_WB1, loadData_WB2);
        end
        drive(idle, idle);
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        pipe_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0);
        run_bundle(mk(0, 0, 0, 1, 128'h40, PAT_A, 7'd1), idle, "store_0x40");
        run_bundle(mk(1, 1, 1, 0, 128'h40, 0, 7'd9), idle, "load_0x40");
    endtask

    task automatic test_passthrough();
        run_bundle(mk(0, 1, 0, 0, 128'd5, 128'h77, 7'd3), mk(0, 1, 0, 0, 128'd9, 0, 7'd4), "nonmem_a");
        run_bundle(mk(1, 0, 0, 0, {4{32'hDEADBEEF}}, 0, 7'd127), mk(1, 1, 0, 0, 128'h1, 0, 7'd0), "nonmem_b");
    endtask

    task automatic test_conflict();
        run_bundle(mk(0, 0, 0, 1, 128'h80, PAT_B, 7'd2), mk(1, 1, 1, 0, 128'h80, 0, 7'd10), "conflict_st_ld");
        run_bundle(mk(1, 1, 1, 0, 128'h40, 0, 7'd11), mk(1, 1, 1, 0, 128'h80, 0, 7'd12), "conflict_ld_ld");
    endtask

    task automatic test_wrap();
        pipe_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0);
        run_bundle(idle, mk(0, 0, 0, 1, 128'h8000, {4{32'h5A5A_0F0F}}, 7'd1), "wrap_store");
        run_bundle(idle, mk(1, 1, 1, 0, 128'h0000, 0, 7'd20), "wrap_load");
        run_bundle(mk(1, 1, 1, 0, 128'h800C, 0, 7'd21), idle, "wrap_load_lowbits");
    endtask

    task automatic test_both_flags();
        pipe_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0);
        run_bundle(idle, mk(1, 1, 1, 1, 128'h200, {4{32'hC0FFEE00}}, 7'd30), "rdwr_pipe2");
        run_bundle(idle, mk(1, 1, 1, 0, 128'h200, 0, 7'd31), "rdwr_verify");
    endtask

    task automatic test_reset_in_serve2();
        pipe_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0);
        run_bundle(mk(0, 0, 0, 1, 128'h100, {4{32'h1234_5678}}, 7'd0), idle, "pre_0x100");
        drive(mk(1, 1, 1, 0, 128'h40, 0, 7'd40), mk(0, 0, 0, 1, 128'h100, {4{32'hBAD0_BAD0}}, 7'd41));
        #1;
        checks++;
        if (stall_MEM !== 1'b1) begin
            errors++;
            $display("FAIL abort_stall got %b want 1", stall_MEM);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (stall_MEM !== 1'b0) begin
            errors++;
            $display("FAIL abort_stall_in_reset got %b want 0", stall_MEM);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({memToReg_WB1, regWriteEnable_WB1, memToReg_WB2, regWriteEnable_WB2, result_WB1, result_WB2,
             loadData_WB1, loadData_WB2, registerRT_WB1, registerRT_WB2} !== '0) begin
            errors++;
            $display("FAIL abort_outputs got r1=%h r2=%h l1=%h want 0", result_WB1, result_WB2, loadData_WB1);
        end
        drive(idle, idle);
        reset = 1'b0;
        sb.delete();
        // A conflicting bundle must stall at once, showing the block came back in IDLE.
        run_bundle(mk(1, 1, 1, 0, 128'h100, 0, 7'd42), mk(1, 1, 1, 0, 128'h40, 0, 7'd43), "abort_reload");
    endtask

    task automatic test_back_to_back();
        pipe_t p [2];
        for (int q = 0; q < 8; q++) begin
            run_bundle(mk(0, 0, 0, 1, 128'(q) << 4, {$urandom, $urandom, $urandom, $urandom}, 7'd0),
                       mk(0, 0, 0, 0, 0, 0, 0), "preload");
        end
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 2; k++) begin
                int kind;
                kind = $urandom_range(0, 3);
                p[k].m2r = 1'($urandom);
                p[k].rwe = 1'($urandom);
                p[k].rt  = 7'($urandom);
                p[k].rc  = {$urandom, $urandom, $urandom, $urandom};
                p[k].res = {$urandom, $urandom, $urandom, $urandom};
                p[k].rd  = (kind == 1) || (kind == 3);
                p[k].wr  = (kind == 2) || (kind == 3);
                if (kind != 0) p[k].res[14:4] = 11'($urandom_range(0, 7));
            end
            run_bundle(p[0], p[1], "random");
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_passthrough();
        test_conflict();
        test_wrap();
        test_both_flags();
        test_reset_in_serve2();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
